// File: rtl/bcd_pkg.sv
// Shared constants and the load-digit range check for the BCD cascade counter.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit,
                                     input logic [BCD_W-1:0] max_digit);
    return (digit <= max_digit);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with a configurable terminal value; carry is combinational so a
// whole cascade advances on a single edge. Optional down-count under BCD_DOWN_EN.
module bcd_digit
  import bcd_pkg::*;
#(
  parameter logic [BCD_W-1:0] WRAP = BCD_MAX
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en_in,
`ifdef BCD_DOWN_EN
  input  logic             down,
`endif
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_r;
  logic [BCD_W-1:0] q_next_s;
  logic             at_end_s;

  // next value and terminal detect for the current count direction
  always_comb begin
    q_next_s = q_r;
    at_end_s = 1'b0;
`ifdef BCD_DOWN_EN
    if (down) begin
      at_end_s = (q_r == 4'd0);
      q_next_s = at_end_s ? WRAP : (q_r - 4'd1);
    end else begin
      at_end_s = (q_r >= WRAP);
      q_next_s = at_end_s ? 4'd0 : (q_r + 4'd1);
    end
`else
    at_end_s = (q_r >= WRAP);
    q_next_s = at_end_s ? 4'd0 : (q_r + 4'd1);
`endif
  end

  // digit register: load wins over count enable
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_r <= 4'd0;
    end else if (load) begin
      q_r <= load_digit;
    end else if (en_in) begin
      q_r <= q_next_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign q     = q_r;
  assign carry = en_in & at_end_s;

endmodule

// File: rtl/bcd_cascade_counter.sv
// Multi-digit BCD counter advanced by a synchronised, edge-detected async tick.
// Define BCD_DOWN_EN to add the 'down' port for borrow/down-count operation.
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MAX_MSD = 9
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      tick_in,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   load_val,
  input  logic                      hold,
`ifdef BCD_DOWN_EN
  input  logic                      down,
`endif
  output logic [BCD_W*DIGITS-1:0]   count,
  output logic                      carry_out,
  output logic                      load_err
);

  localparam logic [BCD_W-1:0] MSD_MAX = 4'(MAX_MSD);

  logic                    sync1_r;
  logic                    sync2_r;
  logic                    prev_r;
  logic [1:0]              fill_r;
  logic                    armed_r;
  logic                    inc_s;
  logic                    carry_out_r;
  logic                    load_err_r;
  logic [BCD_W*DIGITS-1:0] load_clean_s;
  logic                    load_bad_s;
  logic [DIGITS:0]         en_s;

  // synchroniser and edge-detect pipeline
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= tick_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      fill_r  <= {fill_r[0], 1'b1};
      armed_r <= armed_r | (fill_r[1] & ~sync2_r);
    end
  end

  // After reset the edge detector is only armed once a genuinely sampled low
  // has reached sync2, so a tick level held through reset is never counted.
  assign inc_s = sync2_r & ~prev_r & armed_r;

  // sanitise load digits: out-of-range digits load as zero and flag an error
  always_comb begin
    load_clean_s = '0;
    load_bad_s   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_valid(load_val[i*BCD_W +: BCD_W], (i == DIGITS - 1) ? MSD_MAX : BCD_MAX)) begin
        load_clean_s[i*BCD_W +: BCD_W] = load_val[i*BCD_W +: BCD_W];
      end else begin
        load_clean_s[i*BCD_W +: BCD_W] = 4'd0;
        load_bad_s                     = 1'b1;
      end
    end
  end

  assign en_s[0] = inc_s & ~hold & ~load;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam logic [BCD_W-1:0] WRAP_G = (g == DIGITS - 1) ? MSD_MAX : BCD_MAX;
    bcd_digit #(
      .WRAP(WRAP_G)
    ) u_digit (
      .clk       (clk),
      .clear     (clear),
      .en_in     (en_s[g]),
`ifdef BCD_DOWN_EN
      .down      (down),
`endif
      .load      (load),
      .load_digit(load_clean_s[g*BCD_W +: BCD_W]),
      .q         (count[g*BCD_W +: BCD_W]),
      .carry     (en_s[g+1])
    );
  end

  // wrap pulse and sticky load error
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      carry_out_r <= 1'b0;
      load_err_r  <= 1'b0;
    end else begin
      carry_out_r <= en_s[DIGITS];
      load_err_r  <= load_err_r | (load & load_bad_s);
    end
  end

  assign carry_out = carry_out_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: a mod-100 and a mod-60 instance share stimulus
// and are checked against an integer reference model.
module tb_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       tick_in = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       hold = 1'b0;
`ifdef BCD_DOWN_EN
  logic       down = 1'b0;
`endif
  logic [7:0] count_a, count_b;
  logic       carry_a, carry_b, err_a, err_b;

  int vectors = 0;
  int miscompares = 0;

  // reference model: plain integer counts modulo 100 and 60
  int na = 0, nb = 0;
  bit ea = 1'b0, eb = 1'b0;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(2), .MAX_MSD(9)) dut_a (
    .clk(clk), .clear(clear), .tick_in(tick_in), .load(load), .load_val(load_val),
    .hold(hold),
`ifdef BCD_DOWN_EN
    .down(down),
`endif
    .count(count_a), .carry_out(carry_a), .load_err(err_a)
  );

  bcd_cascade_counter #(.DIGITS(2), .MAX_MSD(5)) dut_b (
    .clk(clk), .clear(clear), .tick_in(tick_in), .load(load), .load_val(load_val),
    .hold(hold),
`ifdef BCD_DOWN_EN
    .down(down),
`endif
    .count(count_b), .carry_out(carry_b), .load_err(err_b)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int sanitize(input logic [7:0] v, input int msd_max, output bit bad);
    int lo, hi;
    lo  = int'(v[3:0]);
    hi  = int'(v[7:4]);
    bad = 1'b0;
    if (lo > 9)       begin lo = 0; bad = 1'b1; end
    if (hi > msd_max) begin hi = 0; bad = 1'b1; end
    return hi * 10 + lo;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit ca, input bit cb);
    chk ({tag, "_count_a"}, count_a, to_bcd(na));
    chk ({tag, "_count_b"}, count_b, to_bcd(nb));
    chk1({tag, "_carry_a"}, carry_a, ca);
    chk1({tag, "_carry_b"}, carry_b, cb);
    chk1({tag, "_err_a"}, err_a, ea);
    chk1({tag, "_err_b"}, err_b, eb);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_load(input logic [7:0] v);
    bit bad;
    na = sanitize(v, 9, bad); ea = ea | bad;
    nb = sanitize(v, 5, bad); eb = eb | bad;
  endtask

  task automatic model_count(output bit ca, output bit cb);
    bit dn = 1'b0;
`ifdef BCD_DOWN_EN
    dn = down;
`endif
    if (dn) begin
      ca = (na == 0); na = (na == 0) ? 99 : na - 1;
      cb = (nb == 0); nb = (nb == 0) ? 59 : nb - 1;
    end else begin
      ca = (na == 99); na = (na + 1) % 100;
      cb = (nb == 59); nb = (nb + 1) % 60;
    end
  endtask

  // asynchronous clear mid-cycle, checked before any clock edge
  task automatic do_reset(input string tag);
    #2 clear = 1'b0;
    #1;
    na = 0; nb = 0; ea = 1'b0; eb = 1'b0;
    check_all(tag, 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    step();
    load = 1'b0;
    model_load(v);
    check_all("load", 1'b0, 1'b0);
  endtask

  // one tick: count/carry checked on the update edge, then carry must drop
  task automatic pulse(input int extra_hi, input int lo, input bit co_load, input logic [7:0] co_val);
    bit ca, cb;
    tick_in = 1'b1;
    step(); step();
    if (co_load) begin load = 1'b1; load_val = co_val; end
    step();
    if (co_load) begin
      load = 1'b0; model_load(co_val); ca = 1'b0; cb = 1'b0;
    end else if (hold) begin
      ca = 1'b0; cb = 1'b0;
    end else begin
      model_count(ca, cb);
    end
    check_all("pulse", ca, cb);
    step();
    check_all("pulse_after", 1'b0, 1'b0);
    repeat (extra_hi) step();
    tick_in = 1'b0;
    repeat (lo + 1) step();
  endtask

  initial begin
    // power-on reset
    @(negedge clk);
    @(negedge clk);
    check_all("por", 1'b0, 1'b0);
    clear = 1'b1;
    repeat (3) step();

    // invalid then valid load, then asynchronous clear from 0x37
    do_load(8'hA7);
    do_load(8'h37);
    do_reset("async_clear");
    repeat (3) step();

    // latency: held level counts once, exactly two edges after first sample
    tick_in = 1'b1;
    step(); check_all("lat_n", 1'b0, 1'b0);
    step(); check_all("lat_n1", 1'b0, 1'b0);
    step(); na = 1; nb = 1; check_all("lat_n2", 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(); check_all("lat_hold", 1'b0, 1'b0);
    end
    tick_in = 1'b0;
    repeat (2) step();

    // clear while a tick is in flight; level still high after release must not count
    tick_in = 1'b1;
    step();
    do_reset("mid_clear");
    repeat (6) step();
    check_all("mid_clear_nocount", 1'b0, 1'b0);
    tick_in = 1'b0;
    repeat (2) step();
    pulse(0, 1, 1'b0, 8'h00);

    // full sweep of 100 ticks from zero
    do_reset("sweep_rst");
    repeat (3) step();
    for (int i = 0; i < 100; i++) pulse(0, 1, 1'b0, 8'h00);

    // mod-60 terminal behaviour and invalid MSD load
    do_load(8'h58);
    pulse(0, 1, 1'b0, 8'h00);
    pulse(0, 1, 1'b0, 8'h00);
    do_load(8'h63);
    pulse(1, 2, 1'b0, 8'h00);

    // hold drops the tick, no replay afterwards; load beats a coincident tick
    hold = 1'b1;
    pulse(2, 1, 1'b0, 8'h00);
    hold = 1'b0;
    repeat (4) step();
    check_all("hold_noreplay", 1'b0, 1'b0);
    pulse(0, 1, 1'b1, 8'h42);

`ifdef BCD_DOWN_EN
    do_reset("down_rst");
    repeat (3) step();
    down = 1'b1;
    pulse(0, 1, 1'b0, 8'h00);
    pulse(0, 1, 1'b0, 8'h00);
    do_load(8'h10);
    pulse(0, 1, 1'b0, 8'h00);
    down = 1'b0;
`endif

    // randomized mix of loads, ticks, holds and coincident loads
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        do_load(8'($urandom_range(0, 255)));
      end else begin
        hold = ($urandom_range(0, 3) == 0);
`ifdef BCD_DOWN_EN
        down = 1'($urandom_range(0, 1));
`endif
        pulse($urandom_range(0, 3), $urandom_range(1, 3),
              ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
        hold = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
